// File: rtl/demux4x32_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux4x32_buf
// Purpose  : 1-to-4 word demultiplexer with one holding register per channel,
//            valid/ready on the input and on each output channel.
// Revision : 1.0
// ============================================================================
module demux4x32_buf #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       S,
    input  logic             DValid,
    output logic             DReady,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic [3:0]       YValid,
    input  logic [3:0]       YReady
);

    logic [WIDTH-1:0] r_y [4];
    logic [3:0]       r_valid;
    logic [3:0]       w_sel;
    logic             w_accept;

    // Only the selected channel gates the input; a draining target frees its slot this cycle.
    assign w_sel    = 4'b0001 << S;
    assign DReady   = !r_valid[S] || YReady[S];
    assign w_accept = DValid && DReady;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                r_y[i]     <= '0;
                r_valid[i] <= 1'b0;
            end else if (w_accept && w_sel[i]) begin
                r_y[i]     <= D;
                r_valid[i] <= 1'b1;
            end else if (r_valid[i] && YReady[i]) begin
                r_valid[i] <= 1'b0;
            end
        end
    end

    assign Y0     = r_y[0];
    assign Y1     = r_y[1];
    assign Y2     = r_y[2];
    assign Y3     = r_y[3];
    assign YValid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_demux4x32_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux4x32_buf
// Purpose  : Directed and random stimulus with a per-channel expected-word queue.
// Revision : 1.0
// ============================================================================
module tb_demux4x32_buf;

    logic        Clk;
    logic        Rst;
    logic [31:0] D;
    logic [1:0]  S;
    logic        DValid;
    logic        DReady;
    logic [31:0] Y0, Y1, Y2, Y3;
    logic [3:0]  YValid;
    logic [3:0]  YReady;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q [4][$];

    demux4x32_buf #(.WIDTH(32)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .D      (D),
        .S      (S),
        .DValid (DValid),
        .DReady (DReady),
        .Y0     (Y0),
        .Y1     (Y1),
        .Y2     (Y2),
        .Y3     (Y3),
        .YValid (YValid),
        .YReady (YReady)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ysel(input int i);
        case (i)
            0:       return Y0;
            1:       return Y1;
            2:       return Y2;
            default: return Y3;
        endcase
    endfunction

    // Monitor: compares handshake outputs against queue occupancy, pops on drains, pushes on accepts.
    always @(negedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            chk("rst_yvalid", {28'd0, YValid}, 32'd0);
            chk("rst_dready", {31'd0, DReady}, 32'd1);
        end else begin
            logic exp_rdy;
            exp_rdy = (q[S].size() == 0) || YReady[S];
            chk("dready", {31'd0, DReady}, {31'd0, exp_rdy});
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("yvalid%0d", i), {31'd0, YValid[i]}, {31'd0, q[i].size() != 0});
                if (YValid[i] && YReady[i] && q[i].size() > 0)
                    chk($sformatf("ydata%0d", i), ysel(i), q[i].pop_front());
            end
            if (DValid && exp_rdy) q[S].push_back(D);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] vals [4];

    initial begin
        Rst = 1'b1; D = '0; S = '0; DValid = 1'b0; YReady = '0;
        step(); step();
        chk("init_yvalid", {28'd0, YValid}, 32'd0);
        chk("init_dready", {31'd0, DReady}, 32'd1);
        Rst = 1'b0;

        // Load channels 0 and 2, then reset asynchronously mid-cycle.
        D = 32'h0000_0F00; S = 2'd0; DValid = 1'b1;
        step();
        D = 32'h0000_0F02; S = 2'd2;
        step();
        DValid = 1'b0;
        chk("pre_rst_yvalid", {28'd0, YValid}, 32'h5);
        #2 Rst = 1'b1;
        #1;
        chk("async_yvalid", {28'd0, YValid}, 32'd0);
        chk("async_y0", Y0, 32'd0);
        chk("async_y2", Y2, 32'd0);
        @(negedge Clk);
        step();
        Rst = 1'b0; D = 32'h0000_00A5; S = 2'd2; DValid = 1'b1;
        step();
        DValid = 1'b0;
        chk("post_rst_y2", Y2, 32'h0000_00A5);
        chk("post_rst_yvalid", {28'd0, YValid}, 32'h4);
        YReady = 4'hF; step(); YReady = 4'h0;

        // Steering to all four channels on consecutive cycles.
        vals[0] = 32'h1111_1111; vals[1] = 32'h2222_2222;
        vals[2] = 32'h3333_3333; vals[3] = 32'h4444_4444;
        for (int k = 0; k < 4; k++) begin
            D = vals[k]; S = k[1:0]; DValid = 1'b1;
            #1 chk("steer_dready", {31'd0, DReady}, 32'd1);
            step();
        end
        DValid = 1'b0;
        chk("steer_y0", Y0, 32'h1111_1111);
        chk("steer_y1", Y1, 32'h2222_2222);
        chk("steer_y2", Y2, 32'h3333_3333);
        chk("steer_y3", Y3, 32'h4444_4444);
        chk("steer_yvalid", {28'd0, YValid}, 32'hF);

        // Back-pressure on full channel 1.
        D = 32'hDEAD_BEEF; S = 2'd1; DValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_dready", {31'd0, DReady}, 32'd0);
            step();
            chk("bp_y1", Y1, 32'h2222_2222);
        end
        S = 2'd3;
        #1 chk("allfull_dready", {31'd0, DReady}, 32'd0);
        S = 2'd1; YReady = 4'b0010;
        #1 chk("bp_release_dready", {31'd0, DReady}, 32'd1);
        step();
        DValid = 1'b0; YReady = 4'h0;
        chk("bp_y1_new", Y1, 32'hDEAD_BEEF);
        chk("bp_yvalid1", {31'd0, YValid[1]}, 32'd1);
        YReady = 4'hF; step(); YReady = 4'h0;

        // Pass-through streaming on channel 3.
        S = 2'd3; YReady = 4'b1000;
        for (int k = 1; k <= 8; k++) begin
            D = k; DValid = 1'b1;
            #1 chk("stream_dready", {31'd0, DReady}, 32'd1);
            step();
            chk("stream_y3", Y3, k);
            chk("stream_yvalid3", {31'd0, YValid[3]}, 32'd1);
        end
        DValid = 1'b0;
        step();
        YReady = 4'h0;

        // Accept to channel 2 while channel 0 drains.
        D = 32'hCAFE_0000; S = 2'd0; DValid = 1'b1;
        step();
        D = 32'h1234_5678; S = 2'd2; YReady = 4'b0001;
        step();
        DValid = 1'b0; YReady = 4'h0;
        chk("indep_yvalid", {28'd0, YValid}, 32'h4);
        chk("indep_y0", Y0, 32'hCAFE_0000);
        chk("indep_y2", Y2, 32'h1234_5678);
        YReady = 4'hF; step(); YReady = 4'h0;

        // Random soak.
        for (int k = 0; k < 10000; k++) begin
            D      = $urandom;
            S      = 2'($urandom_range(0, 3));
            DValid = 1'($urandom_range(0, 1));
            YReady = 4'($urandom_range(0, 15));
            step();
        end
        DValid = 1'b0; YReady = 4'hF;
        step(); step();
        YReady = 4'h0;
        chk("final_yvalid", {28'd0, YValid}, 32'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("final_q%0d", i), q[i].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
